cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multi-cycle instruction sequencer for the 8-bit accumulator CPU; sits directly upstream of the accumulator register.
- Steps through an 8-phase fetch/decode/execute cycle per instruction and decodes the current opcode into datapath strobes.
- Drives the accumulator's load enable (ld_ac) and its source select (acc_src: 1 = memory data, 0 = ALU result).
- Also drives the PC, IR, memory and bus strobes, stalls on a memory-ready handshake, and halts on HLT or memory timeout.

Parameters:
- MAX_WAIT, 15, max consecutive stall cycles in a read phase before mem_err; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- opcode  in  3  IR[7:5]; valid from phase OP_ADDR onward
- zero  in  1  accumulator == 0 flag
- mem_ready  in  1  memory read data valid this cycle
- sel  out  1  address mux: 1 = PC, 0 = IR operand field
- rd  out  1  memory read strobe
- ld_ir  out  1  instruction register load
- inc_pc  out  1  PC increment
- ld_pc  out  1  PC load (jump)
- data_e  out  1  accumulator drives data bus
- wr  out  1  memory write strobe
- ld_ac  out  1  accumulator load enable
- acc_src  out  1  accumulator source select: 1 = memory, 0 = ALU
- halt  out  1  CPU halted
- mem_err  out  1  memory-ready timeout occurred (sticky)
- phase  out  3  current phase index, for debug

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- State register: phase 0..7 plus HALTED. Only state and the wait counter are registered.
- Outputs are combinational decode of the registered state and the opcode input.
- Reset (async, rst=1) forces phase=INST_ADDR, wait counter=0, mem_err=0.
- Resulting output values under reset: sel=1, all other strobes 0, halt=0, phase=0.
- Phase decode (0..7):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc. On HLT the next state is HALTED.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - STORE: rd=ALUOP; ld_ac=ALUOP; acc_src=LDA; ld_pc=JMP; wr=STO; data_e=STO.
- Advance: phase increments by 1 each cycle; STORE wraps to INST_ADDR. One instruction takes 8 cycles with no stalls.
- Stall in INST_FETCH: hold the phase while mem_ready=0.
- Stall in OP_FETCH: hold the phase while ALUOP & mem_ready=0. Non-ALUOP opcodes never stall there.
- Stall cycles repeat that phase's outputs unchanged.
- Wait counter:
  - Increments each stalled cycle and clears on any advance.
  - If a stall cycle occurs with the counter equal to MAX_WAIT-1, the next state is HALTED and mem_err sets.
  - mem_ready=1 arriving in that same cycle wins: the phase advances and no error is raised.
- HALTED: halt=1; all strobes 0 (sel=0). mem_err holds its value. Only rst exits this state.
- ld_ac and acc_src are asserted only in STORE. acc_src is 0 whenever ld_ac is 0.
- Reset mid-instruction: immediate async return to INST_ADDR. A partially fetched instruction is discarded.

Decomposition:
- Shared package cpu_pkg:
  - opcode_e enum (HLT..JMP).
  - phase_e enum (INST_ADDR..STORE, HALTED).
  - localparam OPW=3.
- No sub-module. The wait counter stays inline.

Test Plan:
- Reset then LDA (opcode=5), mem_ready=1 throughout:
  - phase runs 0..7 in 8 cycles.
  - In STORE: ld_ac=1, acc_src=1, rd=1. Wrap to phase 0 on the next cycle.
- ADD (opcode=2): in STORE, ld_ac=1 and acc_src=0. STO (opcode=6): data_e=1 in ALU_OP and STORE, wr=1 in STORE only, ld_ac=0.
- SKZ with zero=1: inc_pc=1 in both OP_ADDR and ALU_OP. Same with zero=0: inc_pc=1 in OP_ADDR only. JMP: ld_pc=1 in ALU_OP and STORE.
- Stall: mem_ready=0 for 3 cycles in INST_FETCH then 1 → phase=1 held 4 cycles total, rd=1 throughout, no mem_err.
- Timeout (MAX_WAIT=4): mem_ready stuck 0 in OP_FETCH with ADD → after 4 stall cycles, halt=1 and mem_err=1. Both persist until rst; strobes stay 0.
- HLT (opcode=0) → HALTED after OP_ADDR, halt=1. Async rst pulsed mid-cycle clears it immediately to phase=0, sel=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU: opcode and sequencer phase encodings.
package cpu_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  // Phases 0..7 map straight onto the debug phase index; HALTED sits outside that range.
  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } phase_e;

  function automatic logic is_aluop(input opcode_e op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/cpu_control_fsm.sv
// Eight-phase fetch/decode/execute sequencer; decodes phase and opcode into datapath strobes
// and halts on HLT or when memory fails to answer within MAX_WAIT stall cycles.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           data_e,
  output logic           wr,
  output logic           ld_ac,
  output logic           acc_src,
  output logic           halt,
  output logic           mem_err,
  output logic [2:0]     phase
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  phase_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  opcode_e    op;
  logic       aluop;
  logic       stall;

  assign op      = opcode_e'(opcode);
  assign aluop   = is_aluop(op);
  assign phase   = state_q[2:0];
  assign mem_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INST_ADDR;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    sel     = 1'b0;
    rd      = 1'b0;
    ld_ir   = 1'b0;
    inc_pc  = 1'b0;
    ld_pc   = 1'b0;
    data_e  = 1'b0;
    wr      = 1'b0;
    ld_ac   = 1'b0;
    acc_src = 1'b0;
    halt    = 1'b0;
    stall   = 1'b0;
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;

    case (state_q)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel   = 1'b1;
        rd    = 1'b1;
        stall = !mem_ready;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: inc_pc = 1'b1;
      OP_FETCH: begin
        rd    = aluop;
        stall = aluop && !mem_ready;
      end
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (op == SKZ) && zero;
        ld_pc  = (op == JMP);
        data_e = (op == STO);
      end
      STORE: begin
        rd      = aluop;
        ld_ac   = aluop;
        acc_src = (op == LDA);
        ld_pc   = (op == JMP);
        wr      = (op == STO);
        data_e  = (op == STO);
      end
      HALTED: halt = 1'b1;
      default: ;
    endcase

    // A stall that reaches the wait limit halts, unless mem_ready lands that same cycle.
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (state_q > STORE) begin
      state_d = INST_ADDR;
    end else if (stall) begin
      if (wait_q == WAIT_LAST) begin
        state_d = HALTED;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end else begin
      wait_d = 8'd0;
      if (state_q == OP_ADDR && op == HLT) begin
        state_d = HALTED;
      end else if (state_q == STORE) begin
        state_d = INST_ADDR;
      end else begin
        state_d = phase_e'(state_q + 4'd1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed vector table, hand-written stall/timeout/halt sequences,
// and random stimulus against a behavioural model of the sequencer.
module tb_cpu_control_fsm;
  import cpu_pkg::*;

  localparam int MAXW = 4;

  typedef logic [10:0] outs_t; // {sel,rd,ld_ir,inc_pc,ld_pc,data_e,wr,ld_ac,acc_src,halt,mem_err}

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic       mr;
    int         ph;
    outs_t      exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, data_e, wr, ld_ac, acc_src, halt, mem_err;
  logic [2:0] phase;
  outs_t      act;

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase = 0;
  int m_wait  = 0;
  bit m_halt  = 1'b0;
  bit m_err   = 1'b0;

  vec_t  tbl[$];
  outs_t tails[6][4];

  always #5 clk = ~clk;

  cpu_control_fsm #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .data_e(data_e), .wr(wr), .ld_ac(ld_ac), .acc_src(acc_src),
    .halt(halt), .mem_err(mem_err), .phase(phase)
  );

  assign act = {sel, rd, ld_ir, inc_pc, ld_pc, data_e, wr, ld_ac, acc_src, halt, mem_err};

  function automatic outs_t model_outs(input logic [2:0] op, input logic z);
    int p;
    bit alu;
    p   = m_phase;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (m_halt) return {9'b0, 1'b1, m_err};
    return {p <= 3,
            (p >= 1 && p <= 3) || (p >= 5 && alu),
            p == 2 || p == 3,
            p == 4 || (p == 6 && op == 3'd1 && z),
            p >= 6 && op == 3'd7,
            p >= 6 && op == 3'd6,
            p == 7 && op == 3'd6,
            p == 7 && alu,
            p == 7 && op == 3'd5,
            1'b0,
            m_err};
  endfunction

  task automatic model_step(input logic [2:0] op, input logic mr);
    bit alu, stalled;
    if (m_halt) return;
    alu     = (op >= 3'd2) && (op <= 3'd5);
    stalled = !mr && (m_phase == 1 || (m_phase == 5 && alu));
    if (stalled) begin
      if (m_wait == MAXW - 1) begin
        m_halt = 1'b1;
        m_err  = 1'b1;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
      if (m_phase == 4 && op == 3'd0) m_halt = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic check(input string name, input outs_t exp_o, input int exp_ph);
    n_checks++;
    if (act !== exp_o || (exp_ph >= 0 && phase !== exp_ph[2:0])) begin
      n_fail++;
      $display("FAIL %s: got outs=%b phase=%0d, expected outs=%b phase=%0d",
               name, act, phase, exp_o, exp_ph);
    end
  endtask

  // Entered near a falling edge; drives inputs, checks, crosses one rising edge, returns at the next falling edge.
  task automatic step(input logic [2:0] op, input logic z, input logic mr, input string name,
                      input outs_t exp_o, input int exp_ph, input bit use_model);
    outs_t e;
    int    ep;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    #1;
    e  = exp_o;
    ep = exp_ph;
    if (use_model) begin
      e  = model_outs(op, z);
      ep = m_halt ? -1 : m_phase;
    end
    check(name, e, ep);
    @(posedge clk);
    model_step(op, mr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset", 11'b10000000000, 0);
    #1;
    rst     = 1'b0;
    m_phase = 0;
    m_wait  = 0;
    m_halt  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic add_vec(input logic [2:0] op, input logic z, input int ph, input outs_t exp_o,
                         input string name);
    vec_t v;
    v.op = op; v.z = z; v.mr = 1'b1; v.ph = ph; v.exp = exp_o; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops[6];
    logic       zs[6];
    string      nms[6];

    ops = '{3'd5, 3'd2, 3'd6, 3'd1, 3'd1, 3'd7};
    zs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    nms = '{"lda", "add", "sto", "skz_z1", "skz_z0", "jmp"};
    tails[0] = '{11'b00010000000, 11'b01000000000, 11'b01000000000, 11'b01000001100};
    tails[1] = '{11'b00010000000, 11'b01000000000, 11'b01000000000, 11'b01000001000};
    tails[2] = '{11'b00010000000, 11'b00000000000, 11'b00000100000, 11'b00000110000};
    tails[3] = '{11'b00010000000, 11'b00000000000, 11'b00010000000, 11'b00000000000};
    tails[4] = '{11'b00010000000, 11'b00000000000, 11'b00000000000, 11'b00000000000};
    tails[5] = '{11'b00010000000, 11'b00000000000, 11'b00001000000, 11'b00001000000};
    for (int i = 0; i < 6; i++) begin
      add_vec(ops[i], zs[i], 0, 11'b10000000000, nms[i]);
      add_vec(ops[i], zs[i], 1, 11'b11000000000, nms[i]);
      add_vec(ops[i], zs[i], 2, 11'b11100000000, nms[i]);
      add_vec(ops[i], zs[i], 3, 11'b11100000000, nms[i]);
      for (int p = 0; p < 4; p++) add_vec(ops[i], zs[i], 4 + p, tails[i][p], nms[i]);
    end

    @(negedge clk);
    do_reset();

    // Back-to-back instructions; each first entry also proves the STORE -> INST_ADDR wrap.
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].name, tbl[i].exp, tbl[i].ph, 1'b0);

    // Instruction fetch stall: three not-ready cycles then ready.
    do_reset();
    step(3'd5, 1'b0, 1'b1, "stall_p0", 11'b10000000000, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(3'd5, 1'b0, 1'b0, "stall_hold", 11'b11000000000, 1, 1'b0);
    step(3'd5, 1'b0, 1'b1, "stall_release", 11'b11000000000, 1, 1'b0);
    step(3'd5, 1'b0, 1'b1, "stall_advance", 11'b11100000000, 2, 1'b0);

    // Operand fetch timeout with ADD.
    do_reset();
    step(3'd2, 1'b0, 1'b1, "to_p0", 11'b10000000000, 0, 1'b0);
    step(3'd2, 1'b0, 1'b1, "to_p1", 11'b11000000000, 1, 1'b0);
    step(3'd2, 1'b0, 1'b1, "to_p2", 11'b11100000000, 2, 1'b0);
    step(3'd2, 1'b0, 1'b1, "to_p3", 11'b11100000000, 3, 1'b0);
    step(3'd2, 1'b0, 1'b1, "to_p4", 11'b00010000000, 4, 1'b0);
    for (int i = 0; i < MAXW; i++)
      step(3'd2, 1'b0, 1'b0, "to_stall", 11'b01000000000, 5, 1'b0);
    for (int i = 0; i < 3; i++)
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           "to_halted", 11'b00000000011, -1, 1'b0);

    // HLT, then asynchronous reset in the middle of a cycle.
    do_reset();
    step(3'd0, 1'b0, 1'b1, "hlt_p0", 11'b10000000000, 0, 1'b0);
    step(3'd0, 1'b0, 1'b1, "hlt_p1", 11'b11000000000, 1, 1'b0);
    step(3'd0, 1'b0, 1'b1, "hlt_p2", 11'b11100000000, 2, 1'b0);
    step(3'd0, 1'b0, 1'b1, "hlt_p3", 11'b11100000000, 3, 1'b0);
    step(3'd0, 1'b0, 1'b1, "hlt_p4", 11'b00010000000, 4, 1'b0);
    step(3'd0, 1'b0, 1'b1, "hlt_halted", 11'b00000000010, -1, 1'b0);
    step(3'd5, 1'b1, 1'b0, "hlt_stays", 11'b00000000010, -1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 11'b10000000000, 0);
    @(negedge clk);
    #1;
    rst     = 1'b0;
    m_phase = 0;
    m_wait  = 0;
    m_halt  = 1'b0;
    m_err   = 1'b0;

    // Random opcodes, flags and memory readiness against the model.
    for (int i = 0; i < 800; i++) begin
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
           "random", 11'b0, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
